// File: rtl/booth_r8_pkg.sv
// Shared types for the sequential radix-8 Booth multiplier.
// Digit encoding: sel carries the magnitude 1..4 of a non-zero digit.
package booth_r8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRECOMP,
    ITER,
    DONE
  } state_t;

  typedef struct packed {
    logic       neg;
    logic       zero;
    logic [2:0] sel;
  } booth_digit_t;

  function automatic int ndig(input int width);
    return width / 3 + 1;
  endfunction

endpackage

// File: rtl/booth_r8_digit_encoder.sv
// Radix-8 Booth recoder: 4-bit window {b[3i+2:3i], b[3i-1]}
// to a signed digit in -4..+4.
module booth_r8_digit_encoder
  import booth_r8_pkg::*;
(
  input  logic [3:0]   win,
  output booth_digit_t dig
);

  always_comb begin
    dig      = '0;
    dig.zero = 1'b1;
    unique case (win)
      4'b0000, 4'b1111: dig.zero = 1'b1;
      4'b0001, 4'b0010: dig = '{neg: 1'b0, zero: 1'b0, sel: 3'd1};
      4'b0011, 4'b0100: dig = '{neg: 1'b0, zero: 1'b0, sel: 3'd2};
      4'b0101, 4'b0110: dig = '{neg: 1'b0, zero: 1'b0, sel: 3'd3};
      4'b0111:          dig = '{neg: 1'b0, zero: 1'b0, sel: 3'd4};
      4'b1000:          dig = '{neg: 1'b1, zero: 1'b0, sel: 3'd4};
      4'b1001, 4'b1010: dig = '{neg: 1'b1, zero: 1'b0, sel: 3'd3};
      4'b1011, 4'b1100: dig = '{neg: 1'b1, zero: 1'b0, sel: 3'd2};
      4'b1101, 4'b1110: dig = '{neg: 1'b1, zero: 1'b0, sel: 3'd1};
      default:          dig.zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_radix8_seq_multiplier.sv
// Iterative radix-8 Booth multiplier, one digit per cycle.
// Shift-right accumulator: finished low bits drop into the B register.
module booth_radix8_seq_multiplier
  import booth_r8_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int NDIG = ndig(WIDTH);
  localparam int BW   = 3 * NDIG;
  localparam int AW   = WIDTH + 3;
  localparam int HW   = WIDTH + 4;
  localparam int CW   = $clog2(NDIG + 1);

  state_t         state;
  state_t         state_nx;
  logic [AW-1:0]  a_ext;
  logic [AW-1:0]  x3;
  logic [HW-1:0]  hi;
  logic [BW-1:0]  bx;
  logic           bm1;
  logic [CW-1:0]  cnt;
  logic           last;
  booth_digit_t   dig;
  logic [AW-1:0]  mult;
  logic [HW-1:0]  pp;
  logic [HW-1:0]  sum;
  logic           sa;
  logic           sb;

  assign last = (cnt == CW'(NDIG - 1));
  assign sa   = in_signed & in_a[WIDTH-1];
  assign sb   = in_signed & in_b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = PRECOMP;
      end
      PRECOMP: state_nx = ITER;
      ITER: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  booth_r8_digit_encoder u_enc (
    .win ({bx[2:0], bm1}),
    .dig (dig)
  );

  always_comb begin
    mult = '0;
    if (!dig.zero) begin
      unique case (dig.sel)
        3'd1:    mult = a_ext;
        3'd2:    mult = {a_ext[AW-2:0], 1'b0};
        3'd3:    mult = x3;
        3'd4:    mult = {a_ext[AW-3:0], 2'b00};
        default: mult = '0;
      endcase
    end
  end

  // Negative digits: invert here, the +1 rides in as the adder carry-in.
  assign pp  = {mult[AW-1], mult} ^ {HW{dig.neg}};
  assign sum = hi + pp + {{(HW-1){1'b0}}, dig.neg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_ext <= '0;
      x3    <= '0;
      hi    <= '0;
      bx    <= '0;
      bm1   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext <= {{3{sa}}, in_a};
            bx    <= {{(BW-WIDTH){sb}}, in_b};
            bm1   <= 1'b0;
          end
        end
        PRECOMP: begin
          x3  <= a_ext + {a_ext[AW-2:0], 1'b0};
          hi  <= '0;
          cnt <= '0;
        end
        ITER: begin
          hi  <= {{3{sum[HW-1]}}, sum[HW-1:3]};
          bx  <= {sum[2:0], bx[BW-1:3]};
          bm1 <= bx[2];
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_p = {hi[2*WIDTH-BW-1:0], bx};

endmodule

// File: tb/tb_booth_radix8_seq_multiplier.sv
// Bench for the radix-8 Booth multiplier at WIDTH 32, 8 and 13.
// Scoreboard model is plain integer multiplication.
module tb_booth_radix8_seq_multiplier;
  import booth_r8_pkg::*;

  localparam int WS [3] = '{32, 8, 13};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ia [3];
  logic [31:0] ib [3];
  logic [2:0]  iv, isg, ordy;
  logic [2:0]  ir, ov, bsy;
  logic [63:0] p32;
  logic [15:0] p8;
  logic [25:0] p13;

  logic [3:0]   ew;
  booth_digit_t ed;

  int n_cmp = 0;
  int n_bad = 0;

  booth_radix8_seq_multiplier #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .in_signed(isg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_p(p32), .busy(bsy[0])
  );

  booth_radix8_seq_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_signed(isg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_p(p8), .busy(bsy[1])
  );

  booth_radix8_seq_multiplier #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2][12:0]), .in_b(ib[2][12:0]), .in_signed(isg[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_p(p13), .busy(bsy[2])
  );

  booth_r8_digit_encoder u_enc (.win(ew), .dig(ed));

  function automatic logic [63:0] getp(int k);
    if (k == 0) return p32;
    if (k == 1) return {48'd0, p8};
    return {38'd0, p13};
  endfunction

  function automatic logic [63:0] model(int w, logic [31:0] a,
                                        logic [31:0] b, bit s);
    logic [63:0] m, ua, ub;
    longint      sa, sb;
    m  = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (w < 32) begin
      ua = ua & ((64'd1 << w) - 64'd1);
      ub = ub & ((64'd1 << w) - 64'd1);
    end
    if (!s) return (ua * ub) & m;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - longint'(64'd1 << w);
    if (ub[w-1]) sb = sb - longint'(64'd1 << w);
    return 64'(sa * sb) & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic [63:0] q [3][$];
  int          lat [3];
  bit          lat_on [3];
  bit          hold_v [3];
  logic [63:0] hold_p [3];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        q[k].delete();
        lat_on[k] = 1'b0;
        hold_v[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (lat_on[k]) begin
          lat[k]++;
          if (ov[k]) begin
            chk($sformatf("latency w%0d", WS[k]), 64'(lat[k]),
                64'(ndig(WS[k]) + 2));
            lat_on[k] = 1'b0;
          end else if (lat[k] > 60) begin
            fail($sformatf("latency timeout w%0d", WS[k]));
            lat_on[k] = 1'b0;
          end
        end
        if (ov[k]) begin
          chk($sformatf("in_ready in DONE w%0d", WS[k]), 64'(ir[k]), 0);
          if (hold_v[k])
            chk($sformatf("out_p hold w%0d", WS[k]), getp(k), hold_p[k]);
          if (ordy[k]) begin
            hold_v[k] = 1'b0;
            if (q[k].size() == 0)
              fail($sformatf("spurious result w%0d p=%h", WS[k], getp(k)));
            else
              chk($sformatf("product w%0d", WS[k]), getp(k),
                  q[k].pop_front());
          end else begin
            hold_v[k] = 1'b1;
            hold_p[k] = getp(k);
          end
        end else begin
          if (hold_v[k])
            chk($sformatf("out_valid held w%0d", WS[k]), 64'(ov[k]), 1);
          hold_v[k] = 1'b0;
        end
        if (iv[k] && ir[k]) begin
          q[k].push_back(model(WS[k], ia[k], ib[k], isg[k]));
          lat_on[k] = 1'b1;
          lat[k]    = 0;
        end
      end
    end
  end

  task automatic go(int k, logic [31:0] a, logic [31:0] b, bit s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    ia[k] = a; ib[k] = b; isg[k] = s; iv[k] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ir[k]) begin ok = 1'b1; break; end
    end
    if (!ok) fail($sformatf("accept timeout w%0d", WS[k]));
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic get(int k, logic [63:0] exp, bit use_exp, string nm);
    bit seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ov[k]) begin seen = 1'b1; break; end
    end
    if (!seen) fail({nm, " out_valid timeout"});
    else if (use_exp) chk(nm, getp(k), exp);
    @(posedge clk); #1;
  endtask

  task automatic dir(int k, logic [31:0] a, logic [31:0] b, bit s,
                     logic [63:0] exp, string nm);
    chk({nm, " model"}, model(WS[k], a, b, s), exp);
    go(k, a, b, s);
    get(k, exp, 1'b1, nm);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] one;
    one = 32'd1 << ($urandom % 32);
    case ($urandom % 8)
      0: return 32'd0;
      1: return '1;
      2: return one;
      3: return ~one;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd(int k, bit s, int n);
    int acc = 0;
    int cyc = 0;
    bit drained = 1'b0;
    isg[k] = s;
    while (acc < n && cyc < n * 60) begin
      @(posedge clk); #1;
      iv[k]   = ($urandom % 4) != 0;
      ia[k]   = pick();
      ib[k]   = pick();
      ordy[k] = ($urandom % 4) != 0;
      @(negedge clk);
      if (iv[k] && ir[k]) acc++;
      cyc++;
    end
    if (acc < n) fail($sformatf("random stall w%0d s%0d", WS[k], s));
    @(posedge clk); #1;
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!bsy[k] && q[k].size() == 0) begin drained = 1'b1; break; end
    end
    if (!drained) fail($sformatf("drain w%0d s%0d", WS[k], s));
  endtask

  int dv [16] = '{0, 1, 1, 2, 2, 3, 3, 4, -4, -3, -3, -2, -2, -1, -1, 0};

  initial begin
    iv = '0; isg = '0; ordy = '1;
    for (int k = 0; k < 3; k++) begin ia[k] = '0; ib[k] = '0; end
    ew = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset in_ready w%0d", WS[k]), 64'(ir[k]), 1);
      chk($sformatf("reset out_valid w%0d", WS[k]), 64'(ov[k]), 0);
      chk($sformatf("reset busy w%0d", WS[k]), 64'(bsy[k]), 0);
      chk($sformatf("reset out_p w%0d", WS[k]), getp(k), 0);
    end

    for (int w = 0; w < 16; w++) begin
      int got;
      ew = 4'(w);
      #1;
      got = ed.zero ? 0 : (ed.neg ? -int'(ed.sel) : int'(ed.sel));
      chk($sformatf("encoder win %b", 4'(w)), 64'(got), 64'(dv[w]));
    end

    @(posedge clk); #1;
    rst_n = 1'b1;

    dir(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u32 ff*ff");
    dir(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s32 -1*-1");
    dir(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s32 min*min");
    dir(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, "s32 min*max");
    dir(1, 32'h80, 32'hFF, 1'b1, 64'h0080, "s8 80*ff");
    dir(1, 32'h80, 32'hFF, 1'b0, 64'h7F80, "u8 80*ff");

    // Backpressure: result held, new operands refused.
    ordy[0] = 1'b0;
    go(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (ov[0]) begin seen = 1'b1; break; end
      end
      if (!seen) fail("bp out_valid timeout");
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      iv[0] = ~iv[0];
      ia[0] = $urandom;
      ib[0] = $urandom;
      @(negedge clk);
      chk("bp in_ready low", 64'(ir[0]), 0);
    end
    @(posedge clk); #1;
    iv[0] = 1'b1; ia[0] = 32'd7; ib[0] = 32'd6; isg[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("accept one cycle after handoff", 64'(ir[0]), 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    get(0, 64'd42, 1'b1, "post-bp 7*6");

    // Abort mid-iteration with reset.
    go(0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort in_ready", 64'(ir[0]), 1);
    chk("abort out_valid", 64'(ov[0]), 0);
    chk("abort busy", 64'(bsy[0]), 0);
    chk("abort out_p", p32, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dir(0, 32'd5, 32'd3, 1'b0, 64'd15, "u32 5*3 after abort");

    rnd(0, 1'b0, 400);
    rnd(0, 1'b1, 400);
    rnd(2, 1'b0, 400);
    rnd(2, 1'b1, 400);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
